// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake and registered result
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; default build shifts one bit per cycle.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [3:0]         alu_ctrl_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  result_o,
  output logic               zero_o,
  output logic               illegal_o
);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NAND  = 4'd2;
  localparam logic [3:0] OP_NOR   = 4'd3;
  localparam logic [3:0] OP_ADDU  = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_EQUAL = 4'd7;
  localparam logic [3:0] OP_SFT   = 4'd8;
  localparam logic [3:0] OP_SFTV  = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;

  logic               accept;
  logic               op_ill;
  logic [DATA_W-1:0]  op_res;
  logic [SHAMT_W-1:0] shamt_sel;
  logic               valid_d;
  logic               zero_d;
  logic               ill_d;
  logic [DATA_W-1:0]  result_d;

`ifndef ALU_BARREL_SHIFT_EN
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t             state_q, state_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               is_shift;

  assign ready_o = (state_q == IDLE) && (!valid_o || ready_i);
`else
  assign ready_o = !valid_o || ready_i;
`endif

  assign accept    = valid_i && ready_o;
  assign shamt_sel = (alu_ctrl_i == OP_SFTV) ? src1_i[SHAMT_W-1:0] : shamt_i;

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
    is_shift = 1'b0;
`endif
    case (alu_ctrl_i)
      OP_AND:   op_res = src1_i & src2_i;
      OP_OR:    op_res = src1_i | src2_i;
      OP_NAND:  op_res = ~(src1_i & src2_i);
      OP_NOR:   op_res = ~(src1_i | src2_i);
      OP_ADDU:  op_res = src1_i + src2_i;
      OP_SUBU:  op_res = src1_i - src2_i;
      OP_SLT:   op_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_EQUAL: op_res = {{(DATA_W-1){1'b0}}, (src1_i == src2_i)};
      OP_LUI:   op_res = {src2_i[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
      OP_SFT, OP_SFTV: begin
`ifdef ALU_BARREL_SHIFT_EN
        op_res = DATA_W'($signed(src2_i) >>> shamt_sel);
`else
        // Zero-amount shifts finish immediately with the operand unchanged.
        is_shift = 1'b1;
        op_res   = src2_i;
`endif
      end
      default:  op_ill = 1'b1;
    endcase
  end

  always_comb begin
    valid_d  = valid_o;
    result_d = result_o;
    zero_d   = zero_o;
    ill_d    = illegal_o;
`ifndef ALU_BARREL_SHIFT_EN
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    if (state_q == SHIFT) begin
      work_d  = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
      count_d = count_q - SHAMT_W'(1);
      if (count_q == SHAMT_W'(1)) begin
        result_d = work_d;
        zero_d   = (work_d == '0);
        ill_d    = 1'b0;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
    end else begin
`endif
      if (valid_o && ready_i) begin
        valid_d = 1'b0;
      end
      if (accept) begin
`ifndef ALU_BARREL_SHIFT_EN
        if (is_shift && (shamt_sel != '0)) begin
          work_d  = src2_i;
          count_d = shamt_sel;
          state_d = SHIFT;
          valid_d = 1'b0;
        end else begin
`endif
          result_d = op_res;
          zero_d   = (op_res == '0);
          ill_d    = op_ill;
          valid_d  = 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
        end
`endif
      end
`ifndef ALU_BARREL_SHIFT_EN
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      state_q   <= IDLE;
      work_q    <= '0;
      count_q   <= '0;
`endif
    end else begin
      valid_o   <= valid_d;
      result_o  <= result_d;
      zero_o    <= zero_d;
      illegal_o <= ill_d;
`ifndef ALU_BARREL_SHIFT_EN
      state_q   <= state_d;
      work_q    <= work_d;
      count_q   <= count_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - randomized self-checking bench for alu_exec_unit against a behavioural model
module tb_alu_exec_unit;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  alu_ctrl_i = 4'd0;
  logic [31:0] src1_i = 32'd0;
  logic [31:0] src2_i = 32'd0;
  logic [4:0]  shamt_i = 5'd0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit rnd_ready = 1'b0;

  // Model state: visible output plus a pending shift result and its remaining cycles.
  logic        m_valid = 1'b0;
  logic        m_zero  = 1'b0;
  logic        m_ill   = 1'b0;
  logic [31:0] m_res   = 32'd0;
  logic [31:0] m_pend  = 32'd0;
  int          m_busy  = 0;
  logic        m_acc;
  logic [32:0] m_out;
  int          m_lat;

  alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_ctrl_i(alu_ctrl_i), .src1_i(src1_i), .src2_i(src2_i), .shamt_i(shamt_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .zero_o(zero_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    r = 32'd0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = ~(a & b);
      4'd3:  r = ~(a | b);
      4'd4:  r = a + b;
      4'd5:  r = a - b;
      4'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  r = (a == b) ? 32'd1 : 32'd0;
      4'd8:  r = $signed(b) >>> sh;
      4'd9:  r = $signed(b) >>> a[4:0];
      4'd10: r = b << 16;
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] c, input logic [31:0] a, input logic [4:0] sh);
    if (BARREL) return 0;
    if (c == 4'd8) return int'(sh);
    if (c == 4'd9) return int'(a[4:0]);
    return 0;
  endfunction

  initial forever begin
    @(posedge clk_i or posedge rst_i);
    if (rst_i) begin
      m_valid = 1'b0; m_zero = 1'b0; m_ill = 1'b0; m_res = 32'd0; m_busy = 0;
    end else begin
      m_acc = valid_i && (m_busy == 0) && (!m_valid || ready_i);
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1; m_res = m_pend; m_zero = (m_pend == 32'd0); m_ill = 1'b0;
        end
      end else begin
        if (m_valid && ready_i) m_valid = 1'b0;
        if (m_acc) begin
          m_out = ref_op(alu_ctrl_i, src1_i, src2_i, shamt_i);
          m_lat = ref_lat(alu_ctrl_i, src1_i, shamt_i);
          if (m_lat > 0) begin
            m_busy = m_lat; m_pend = m_out[31:0]; m_valid = 1'b0;
          end else begin
            m_valid = 1'b1; m_res = m_out[31:0];
            m_zero = (m_out[31:0] == 32'd0); m_ill = m_out[32];
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (chk_en) begin
      chk("ready_o", ready_o, (m_busy == 0) && (!m_valid || ready_i));
      chk("valid_o", valid_o, m_valid);
      chk("result_o", result_o, m_res);
      chk("zero_o", zero_o, m_zero);
      chk("illegal_o", illegal_o, m_ill);
    end
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (rnd_ready) ready_i = ($urandom % 3) != 0;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh);
    bit ok;
    ok = 1'b0;
    valid_i = 1'b1; alu_ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int stall;
    logic [3:0]  c;
    logic [31:0] a, b;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_zero", zero_o, 0);
    chk("rst_illegal", illegal_o, 0);
    step();
    rst_i = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    step();

    send(4'd4, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0);
    @(negedge clk_i);
    chk("addu_valid", valid_o, 1);
    chk("addu_result", result_o, 32'h0000_0001);
    chk("addu_zero", zero_o, 0);
    step();
    send(4'd6, 32'hFFFF_FFFE, 32'h0000_0001, 5'd0);
    @(negedge clk_i);
    chk("slt_result", result_o, 32'h1);
    step();
    send(4'd5, 32'd5, 32'd5, 5'd0);
    @(negedge clk_i);
    chk("subu_result", result_o, 32'h0);
    chk("subu_zero", zero_o, 1);
    step();

    send(4'd9, 32'h0000_0004, 32'h8000_0000, 5'd0);
    stall = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (valid_o) break;
      if (!ready_o) stall++;
    end
    chk("sftv_stall", stall, BARREL ? 0 : 4);
    chk("sftv_result", result_o, 32'hF800_0000);
    step();

    send(4'd4, 32'd10, 32'd20, 5'd0);
    ready_i = 1'b0;
    valid_i = 1'b1; alu_ctrl_i = 4'd0; src1_i = 32'h0000_F0F0; src2_i = 32'h0000_FF00;
    repeat (3) begin
      @(negedge clk_i);
      chk("hold_result", result_o, 32'd30);
      chk("hold_ready", ready_o, 0);
    end
    step();
    ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("and_result", result_o, 32'h0000_F000);
    step();

    send(4'd10, 32'd0, 32'h0000_1234, 5'd0);
    @(negedge clk_i);
    chk("lui_result", result_o, 32'h1234_0000);
    step();
    send(4'd12, 32'h1111_1111, 32'h2222_2222, 5'd3);
    @(negedge clk_i);
    chk("illegal_result", result_o, 32'h0);
    chk("illegal_flag", illegal_o, 1);
    step();

    send(4'd8, 32'd0, 32'h8765_4321, 5'd20);
    repeat (3) step();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("abort_valid", valid_o, 0);
    chk("abort_result", result_o, 0);
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_ready", ready_o, 1);
    step();
    send(4'd4, 32'd3, 32'd4, 5'd0);
    @(negedge clk_i);
    chk("post_abort_addu", result_o, 32'd7);
    step();

    rnd_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom % 4 == 0) step();
      c = 4'($urandom % 16);
      a = $urandom;
      b = ($urandom % 4 == 0) ? a : $urandom;
      if ($urandom % 3 == 0) a = a & 32'h8000_001F;
      send(c, a, b, 5'($urandom));
    end
    rnd_ready = 1'b0;
    ready_i = 1'b1;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that sits directly downstream of the ALU control decode.
- Consumes the 4-bit ALU control code plus two operands and a shift amount, and produces a registered result and a zero flag.
- Uses a valid/ready handshake on both sides.
- Logic/arithmetic ops complete in one cycle; right shifts run iteratively, one bit per cycle, so the stage stalls upstream while shifting.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  upstream has an operation.
- ready_o  output  1  stage can accept an operation this cycle.
- alu_ctrl_i  input  4  operation code: AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6, EQUAL=7, SFT=8, SFTV=9, LUI=10; 11-15 illegal.
- src1_i  input  DATA_W  operand A (rs).
- src2_i  input  DATA_W  operand B (rt or extended immediate).
- shamt_i  input  SHAMT_W  constant shift amount for SFT.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- result_o  output  DATA_W  registered result.
- zero_o  output  1  result_o == 0.
- illegal_o  output  1  accepted code was 11-15; qualified by valid_o.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to IDLE.
  - valid_o=0, result_o=0, zero_o=0, illegal_o=0, shift counter=0.
  - ready_o=1 from the first cycle after reset deasserts.
  - Reset mid-shift aborts the operation; no result is produced.
- States: IDLE, SHIFT.
- ready_o = (state==IDLE) && (!valid_o || ready_i); combinational. Accept = valid_i && ready_o.
- IDLE, accept of codes 0-7, 10, or 11-15:
  - result_o, zero_o, illegal_o and valid_o=1 are registered on the same edge (latency 1 cycle).
  - Stay in IDLE.
- Operations (all wrap modulo 2^DATA_W; no overflow detection):
  - AND/OR/NAND/NOR: bitwise.
  - ADDU: src1+src2.
  - SUBU: src1-src2.
  - SLT: signed compare, 1 if src1<src2 else 0.
  - EQUAL: 1 if src1==src2 else 0.
  - LUI: src2 << (DATA_W/2), low half zeroed.
  - Illegal codes (11-15): result 0, illegal_o=1.
- SFT: arithmetic right shift of src2 by shamt_i.
- SFTV: arithmetic right shift of src2 by src1[SHAMT_W-1:0].
- Shift with amount 0: behaves like a 1-cycle op (result = src2).
- Shift with amount N>0:
  - On accept, latch src2 into the work register, load count=N, go to SHIFT; valid_o deasserts in the same edge unless it was held.
  - SHIFT: each cycle, work = {work[MSB], work[MSB:1]} and count decrements.
  - When count reaches 1, the final shifted value is written to result_o, valid_o=1, and state returns to IDLE.
  - Total latency = N cycles from accept to valid_o; ready_o=0 throughout SHIFT.
- Output hold: while valid_o && !ready_i, result_o/zero_o/illegal_o are stable and no new accept occurs.
- Simultaneous drain and accept in IDLE (valid_o && ready_i && valid_i) is allowed: the new result replaces the old on the same edge, giving back-to-back throughput of 1 op/cycle.
- Drain without a new accept: valid_o clears; result_o holds its last value.
- Inputs are sampled only at accept; changes while stalled are ignored.

Optional Feature:
- Macro ALU_BARREL_SHIFT_EN.
- Defined:
  - SFT/SFTV use a combinational barrel shifter and complete in 1 cycle like the other ops.
  - The SHIFT state and counter are not built.
  - ready_o = !valid_o || ready_i.
- Undefined: iterative shifter as above, N-cycle latency.

Test Plan:
- Reset then ADDU src1=0xFFFFFFFF, src2=0x00000002, ready_i=1 -> after 1 cycle: valid_o=1, result_o=0x00000001, zero_o=0.
- SLT src1=0xFFFFFFFE (-2), src2=0x00000001 -> result_o=1; SUBU 5-5 -> result_o=0, zero_o=1.
- SFTV src1=0x00000004, src2=0x80000000 -> ready_o=0 for 4 cycles, then result_o=0xF8000000. With ALU_BARREL_SHIFT_EN: same result after 1 cycle.
- ready_i=0 with valid_o=1 for 3 cycles while valid_i=1 (AND 0xF0F0,0xFF00) -> result_o held, no accept; ready_i=1 -> AND result 0x0000F000 on the next edge.
- LUI src2=0x00001234 -> 0x12340000; alu_ctrl_i=12 -> result_o=0, illegal_o=1.
- SFT shamt_i=20 in progress; assert rst_i at cycle 5 -> valid_o=0, result_o=0, ready_o=1 after release; the next ADDU completes normally.
